axi_spi_master: RTL and testbench
=================================

AXI_SPI_MASTER -- requirements
Module: axi_spi_master

Interface
REQ-001 SHALL have parameter DATA_W, 8, SPI word width in bits (8..32).
REQ-002 SHALL have parameter NUM_CS, 1, number of chip-select lines (1..8).
REQ-003 SHALL have parameter FIFO_DEPTH, 8, TX and RX FIFO depth in words (power of 2, 2..16).
REQ-004 SHALL have ports as follows; reset resetn, synchronous, active-low; clock clk:
- clk  in  1  system clock; all logic on its rising edge
- resetn  in  1  synchronous active-low reset
- s_axi_awaddr  in  12  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  write byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  12  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- spi_sclk  out  1  SPI serial clock
- spi_mosi  out  1  SPI data out
- spi_miso  in  1  SPI data in
- spi_cs_n  out  NUM_CS  active-low chip selects
- irq  out  1  level interrupt

Function
REQ-005 SHALL decode awaddr/araddr[4:2]:
- 0x00 CTRL: [0] EN, [1] CPOL, [2] CPHA, [3] IRQ_EN, [10:8] CS_SEL; write-1-self-clear flushes: [16] TX, [17] RX.
- 0x04 DIV: [15:0].
- 0x08 TXDATA: write pushes wdata[DATA_W-1:0]; reads 0.
- 0x0C RXDATA: read pops the RX FIFO; reads 0 when empty.
- 0x10 STATUS: [0] BUSY, [1] TX_FULL, [2] TX_EMPTY, [3] RX_FULL, [4] RX_EMPTY, [5] RX_OVF (sticky, write-1-clear), [12:8] TX level, [20:16] RX level.
REQ-006 Write handshake:
- Accept only when awvalid and wvalid are both high and bvalid is low.
- awready and wready pulse high together for exactly 1 cycle.
- bvalid rises on the next cycle and holds until bready.
REQ-007 Read handshake:
- Accept when arvalid is high and rvalid is low.
- arready pulses for 1 cycle; rvalid and rdata follow on the next cycle.
- rdata is stable until rready.
REQ-008 Unmapped address (offsets 0x14..0xFFF) SHALL give SLVERR (2'b10); writes are ignored; reads return 0.
REQ-009 A write with wstrb=0 SHALL be a no-op with OKAY; otherwise the whole register is written.
REQ-010 A TXDATA write with the TX FIFO full SHALL be dropped with bresp SLVERR; FIFO contents are unchanged.
REQ-011 Engine FSM transitions:
- IDLE->LEAD when EN=1 and TX FIFO is not empty.
- LEAD (cs_n[CS_SEL] low, one half-period) -> SHIFT.
- SHIFT (DATA_W sclk cycles, MSB first) -> next word if TX is not empty, else TRAIL.
- TRAIL (one half-period) -> GAP (cs_n high, one half-period) -> IDLE.
REQ-012 sclk half-period SHALL be DIV+1 clk cycles; sclk idles at CPOL.
- CPHA=0: mosi is set up before the first edge and miso is sampled on leading edges.
- CPHA=1: mosi changes on leading edges and miso is sampled on trailing edges.
REQ-013 Each received word SHALL be pushed to the RX FIFO after its last sample; if RX is full, the word is dropped and RX_OVF is set.
REQ-014 CS_SEL >= NUM_CS SHALL keep all cs_n high while shifting still occurs.
REQ-015 CTRL/DIV writes while BUSY SHALL take effect only at the next IDLE->LEAD transition.
- Exception: EN cleared aborts the transfer immediately: FSM to IDLE, cs_n all high, sclk=CPOL, partial word discarded.
REQ-016 Simultaneous FIFO push and pop on the same cycle SHALL both succeed and leave the level unchanged; flush overrides push.
REQ-017 irq SHALL equal IRQ_EN & (RX not empty | RX_OVF | (TX empty & !BUSY)).

Reset
REQ-018 On resetn=0 the block SHALL drive all outputs low except spi_cs_n (all 1) and spi_sclk (0).
REQ-019 On resetn=0 the block SHALL clear all registers, empty both FIFOs and put the FSM in IDLE.
REQ-020 Reset asserted mid-transfer SHALL take effect the next clk edge, with no further sclk edges.

Verification
REQ-021 DATA_W=8, DIV=1, mode 0, miso tied to mosi: push 0xA5 -> 8 sclk periods of 4 clk; RXDATA reads 0xA5; cs_n[0] high again with BUSY=0.
REQ-022 Push 0x3C and 0xC3 back-to-back with CS_SEL=2 -> cs_n[2] stays low across both words with no gap; RX holds 0x3C then 0xC3.
REQ-023 Modes 1, 2 and 3 against a bench slave returning 0x5A -> RXDATA=0x5A each time; sclk idle level equals CPOL.
REQ-024 Push FIFO_DEPTH+1 words with EN=0 -> last write gets bresp 2'b10; STATUS TX_FULL=1, TX level=FIFO_DEPTH.
REQ-025 Run FIFO_DEPTH+1 transfers without reading -> RX_OVF=1; writing 0x20 to STATUS clears it; a read of 0x14 gives SLVERR with rdata 0.
REQ-026 Clear EN, or assert resetn=0, at bit 3 of a word -> cs_n all high on the next cycle; RX level unchanged; no further sclk toggles.

Source files
------------

// File: rtl/axi_spi_master.sv
// AXI4-Lite register front end with TX/RX FIFOs driving a SPI master shift engine.
// CPOL/CPHA/CS_SEL/DIV are latched when a burst starts; clearing EN aborts at once.
module axi_spi_master #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_CS     = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [11:0]       s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [11:0]       s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              irq
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = $clog2(2 * DATA_W);
  localparam int unsigned LastEdge = 2 * DATA_W - 1;
  localparam logic [1:0] RespOkay = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [2:0] {StIdle, StLead, StShift, StTrail, StGap} state_e;

  logic aw_rdy_q, aw_rdy_d, b_valid_q, b_valid_d, ar_rdy_q, ar_rdy_d, r_valid_q, r_valid_d;
  logic [1:0] b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic [31:0] r_data_q, r_data_d;
  logic en_q, en_d, cpol_q, cpol_d, cpha_q, cpha_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
  logic [2:0] cs_sel_q, cs_sel_d, cs_a_q, cs_a_d;
  logic [15:0] div_q, div_d, div_a_q, div_a_d, cnt_q, cnt_d;
  logic cpol_a_q, cpol_a_d, cpha_a_q, cpha_a_d;
  state_e st_q, st_d;
  logic [EW-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_wdata, ld_word;
  logic sclk_q, sclk_d, mosi_q, mosi_d;
  logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic tx_push, tx_pop, rx_push, rx_push_req, rx_pop, tx_flush, rx_flush, load, ld_cpha;
  logic tx_full, tx_empty, rx_full, rx_empty, busy, tick, lead_edge, sample;
  logic wr_mapped, rd_mapped;
  logic [31:0] ctrl_rd, status_rd;
  logic unused_bits;

  assign tx_full   = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty  = (tx_cnt_q == '0);
  assign rx_full   = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty  = (rx_cnt_q == '0);
  assign busy      = (st_q != StIdle);
  assign tick      = (cnt_q == div_a_q);
  assign wr_mapped = (s_axi_awaddr[11:5] == '0) && (s_axi_awaddr[4:2] <= 3'd4);
  assign rd_mapped = (s_axi_araddr[11:5] == '0) && (s_axi_araddr[4:2] <= 3'd4);
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata};

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[3:0]  = {irq_en_q, cpha_q, cpol_q, en_q};
    ctrl_rd[10:8] = cs_sel_q;
    status_rd = '0;
    status_rd[5:0]   = {ovf_q, rx_empty, rx_full, tx_empty, tx_full, busy};
    status_rd[12:8]  = 5'(tx_cnt_q);
    status_rd[20:16] = 5'(rx_cnt_q);
  end

  always_comb begin
    aw_rdy_d = s_axi_awvalid && s_axi_wvalid && !b_valid_q && !aw_rdy_q;
    ar_rdy_d = s_axi_arvalid && !r_valid_q && !ar_rdy_q;
    b_valid_d = b_valid_q && !s_axi_bready;
    r_valid_d = r_valid_q && !s_axi_rready;
    b_resp_d = b_resp_q;  r_resp_d = r_resp_q;  r_data_d = r_data_q;
    en_d = en_q;  cpol_d = cpol_q;  cpha_d = cpha_q;  irq_en_d = irq_en_q;
    cs_sel_d = cs_sel_q;  div_d = div_q;  ovf_d = ovf_q;
    cpol_a_d = cpol_a_q;  cpha_a_d = cpha_a_q;  cs_a_d = cs_a_q;  div_a_d = div_a_q;
    st_d = st_q;  edge_d = edge_q;  tx_sh_d = tx_sh_q;  rx_sh_d = rx_sh_q;
    sclk_d = sclk_q;  mosi_d = mosi_q;
    cnt_d = tick ? '0 : cnt_q + 16'd1;
    tx_push = 1'b0;  tx_pop = 1'b0;  rx_push = 1'b0;  rx_push_req = 1'b0;  rx_pop = 1'b0;
    tx_flush = 1'b0;  rx_flush = 1'b0;  load = 1'b0;  ld_cpha = cpha_a_q;  ld_word = '0;
    rx_wdata = rx_sh_q;  lead_edge = 1'b0;  sample = 1'b0;
    tx_wp_d = tx_wp_q;  tx_rp_d = tx_rp_q;  tx_cnt_d = tx_cnt_q;
    rx_wp_d = rx_wp_q;  rx_rp_d = rx_rp_q;  rx_cnt_d = rx_cnt_q;

    // Write takes effect in the cycle the ready pulse is visible to the master.
    if (aw_rdy_q) begin
      b_valid_d = 1'b1;
      b_resp_d  = wr_mapped ? RespOkay : RespSlvErr;
      if (wr_mapped && s_axi_wstrb != 4'b0) begin
        case (s_axi_awaddr[4:2])
          3'd0: begin
            {irq_en_d, cpha_d, cpol_d, en_d} = s_axi_wdata[3:0];
            cs_sel_d = s_axi_wdata[10:8];
            tx_flush = s_axi_wdata[16];
            rx_flush = s_axi_wdata[17];
          end
          3'd1: div_d = s_axi_wdata[15:0];
          3'd2: begin
            if (tx_full) b_resp_d = RespSlvErr;
            else         tx_push  = 1'b1;
          end
          3'd4: if (s_axi_wdata[5]) ovf_d = 1'b0;
          default: ;
        endcase
      end
    end

    if (ar_rdy_q) begin
      r_valid_d = 1'b1;
      r_resp_d  = rd_mapped ? RespOkay : RespSlvErr;
      r_data_d  = '0;
      if (rd_mapped) begin
        case (s_axi_araddr[4:2])
          3'd0: r_data_d = ctrl_rd;
          3'd1: r_data_d = {16'b0, div_q};
          3'd3: if (!rx_empty) begin
            r_data_d = 32'(rx_mem_q[rx_rp_q]);
            rx_pop   = 1'b1;
          end
          3'd4: r_data_d = status_rd;
          default: ;
        endcase
      end
    end

    case (st_q)
      StIdle: begin
        sclk_d = cpol_q;
        cnt_d  = '0;
        if (en_q && !tx_empty) begin
          cpol_a_d = cpol_q;  cpha_a_d = cpha_q;  cs_a_d = cs_sel_q;  div_a_d = div_q;
          ld_cpha = cpha_q;
          load    = 1'b1;
          st_d    = StLead;
        end
      end
      StLead: if (tick) st_d = StShift;
      StShift: begin
        if (tick) begin
          sclk_d    = !sclk_q;
          lead_edge = !edge_q[0];
          sample    = lead_edge ^ cpha_a_q;
          edge_d    = edge_q + EW'(1);
          if (sample) rx_wdata = {rx_sh_q[DATA_W-2:0], spi_miso};
          rx_sh_d = rx_wdata;
          if (!sample && edge_q != EW'(LastEdge)) begin
            mosi_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = tx_sh_q << 1;
          end
          if (edge_q == EW'(LastEdge)) begin
            rx_push_req = 1'b1;
            if (!tx_empty) load = 1'b1;
            else           st_d = StTrail;
          end
        end
      end
      StTrail: if (tick) st_d = StGap;
      StGap:   if (tick) st_d = StIdle;
      default: st_d = StIdle;
    endcase

    // Clearing EN kills the burst on the same edge, dropping any partial word.
    if (!en_d) begin
      st_d = StIdle;  sclk_d = cpol_d;  cnt_d = '0;
      load = 1'b0;  rx_push_req = 1'b0;
    end

    if (load) begin
      ld_word = tx_mem_q[tx_rp_q];
      tx_pop  = 1'b1;
      edge_d  = '0;
      cnt_d   = '0;
      if (ld_cpha) begin
        tx_sh_d = ld_word;
      end else begin
        mosi_d  = ld_word[DATA_W-1];
        tx_sh_d = ld_word << 1;
      end
    end

    if (rx_push_req) begin
      if (!rx_full || rx_pop) rx_push = 1'b1;
      else                    ovf_d   = 1'b1;
    end

    if (tx_flush) begin
      tx_wp_d = '0;  tx_rp_d = '0;  tx_cnt_d = '0;
    end else begin
      if (tx_push) tx_wp_d = tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_d = tx_rp_q + AW'(1);
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end
    if (rx_flush) begin
      rx_wp_d = '0;  rx_rp_d = '0;  rx_cnt_d = '0;
    end else begin
      if (rx_push) rx_wp_d = rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_d = rx_rp_q + AW'(1);
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push && !tx_flush) tx_mem_q[tx_wp_q] <= s_axi_wdata[DATA_W-1:0];
    if (rx_push && !rx_flush) rx_mem_q[rx_wp_q] <= rx_wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_rdy_q <= 1'b0;  b_valid_q <= 1'b0;  b_resp_q <= '0;
      ar_rdy_q <= 1'b0;  r_valid_q <= 1'b0;  r_resp_q <= '0;  r_data_q <= '0;
      en_q <= 1'b0;  cpol_q <= 1'b0;  cpha_q <= 1'b0;  irq_en_q <= 1'b0;  ovf_q <= 1'b0;
      cs_sel_q <= '0;  div_q <= '0;
      cpol_a_q <= 1'b0;  cpha_a_q <= 1'b0;  cs_a_q <= '0;  div_a_q <= '0;
      st_q <= StIdle;  cnt_q <= '0;  edge_q <= '0;  tx_sh_q <= '0;  rx_sh_q <= '0;
      sclk_q <= 1'b0;  mosi_q <= 1'b0;
      tx_wp_q <= '0;  tx_rp_q <= '0;  tx_cnt_q <= '0;
      rx_wp_q <= '0;  rx_rp_q <= '0;  rx_cnt_q <= '0;
    end else begin
      aw_rdy_q <= aw_rdy_d;  b_valid_q <= b_valid_d;  b_resp_q <= b_resp_d;
      ar_rdy_q <= ar_rdy_d;  r_valid_q <= r_valid_d;  r_resp_q <= r_resp_d;  r_data_q <= r_data_d;
      en_q <= en_d;  cpol_q <= cpol_d;  cpha_q <= cpha_d;  irq_en_q <= irq_en_d;  ovf_q <= ovf_d;
      cs_sel_q <= cs_sel_d;  div_q <= div_d;
      cpol_a_q <= cpol_a_d;  cpha_a_q <= cpha_a_d;  cs_a_q <= cs_a_d;  div_a_q <= div_a_d;
      st_q <= st_d;  cnt_q <= cnt_d;  edge_q <= edge_d;  tx_sh_q <= tx_sh_d;  rx_sh_q <= rx_sh_d;
      sclk_q <= sclk_d;  mosi_q <= mosi_d;
      tx_wp_q <= tx_wp_d;  tx_rp_q <= tx_rp_d;  tx_cnt_q <= tx_cnt_d;
      rx_wp_q <= rx_wp_d;  rx_rp_q <= rx_rp_d;  rx_cnt_q <= rx_cnt_d;
    end
  end

  // An out-of-range CS_SEL matches no line, so all chip selects stay high.
  always_comb begin
    spi_cs_n = '1;
    if (st_q == StLead || st_q == StShift || st_q == StTrail) begin
      for (int unsigned i = 0; i < NUM_CS; i++) begin
        if (cs_a_q == 3'(i)) spi_cs_n[i] = 1'b0;
      end
    end
  end

  assign s_axi_awready = aw_rdy_q;
  assign s_axi_wready  = aw_rdy_q;
  assign s_axi_bvalid  = b_valid_q;
  assign s_axi_bresp   = b_resp_q;
  assign s_axi_arready = ar_rdy_q;
  assign s_axi_rvalid  = r_valid_q;
  assign s_axi_rresp   = r_resp_q;
  assign s_axi_rdata   = r_data_q;
  assign spi_sclk      = sclk_q;
  assign spi_mosi      = mosi_q;
  assign irq           = irq_en_q && (!rx_empty || ovf_q || (tx_empty && !busy));
endmodule

// File: tb/tb_axi_spi_master.sv
// Directed bench for axi_spi_master: loopback and modelled-slave transfers, FIFO limits,
// overflow, error responses and abort by EN clear or reset.
module tb_axi_spi_master;
  localparam int unsigned DW = 8;
  localparam int unsigned NCS = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [11:0] ACtrl = 12'h000, ADiv = 12'h004, ATx = 12'h008;
  localparam logic [11:0] ARx = 12'h00C, AStat = 12'h010;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [11:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
  logic s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;
  logic spi_sclk, spi_mosi, spi_miso, irq;
  logic [NCS-1:0] spi_cs_n;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  axi_spi_master #(.DATA_W(DW), .NUM_CS(NCS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .irq(irq)
  );

  // Monitors: clock counter, sclk toggles and rises, chip-select edges.
  int cyc = 0, sclk_tog = 0, rise_prev = 0, rise_last = 0;
  int cs0_fall = 0, cs2_fall = 0, cs2_rise = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(spi_sclk) sclk_tog = sclk_tog + 1;
  always @(posedge spi_sclk) begin rise_prev = rise_last; rise_last = cyc; end
  always @(negedge spi_cs_n[0]) cs0_fall = cs0_fall + 1;
  always @(negedge spi_cs_n[2]) cs2_fall = cs2_fall + 1;
  always @(posedge spi_cs_n[2]) cs2_rise = cs2_rise + 1;

  // Slave on cs_n[0] answering 0x5A in the configured mode, or plain loopback.
  logic slv_on = 1'b0, slv_cpol = 1'b0, slv_cpha = 1'b0, slv_out = 1'b0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [7:0] slv_sh = 8'h5A;
  always @(spi_sclk or spi_cs_n[0]) begin
    if (spi_cs_n[0] !== prev_cs && spi_cs_n[0] == 1'b0) begin
      slv_sh = 8'h5A;  slv_out = 1'b0;
    end else if (spi_cs_n[0] == 1'b0 && spi_sclk !== prev_sclk) begin
      if (slv_cpha && (spi_sclk != slv_cpol)) begin
        slv_out = slv_sh[7];  slv_sh = slv_sh << 1;
      end else if (!slv_cpha && (spi_sclk == slv_cpol)) begin
        slv_sh = slv_sh << 1;
      end
    end
    prev_cs = spi_cs_n[0];
    prev_sclk = spi_sclk;
  end
  assign spi_miso = !slv_on ? spi_mosi : (slv_cpha ? slv_out : slv_sh[7]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    @(negedge clk);
    s_axi_awaddr = a;  s_axi_wdata = d;  s_axi_wstrb = s;
    s_axi_awvalid = 1'b1;  s_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 20) begin @(negedge clk); n++; end
    check("awready_seen", 32'(s_axi_awready && s_axi_wready), 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;  s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
    check("bvalid_seen", 32'(s_axi_bvalid), 1);
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    s_axi_araddr = a;  s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
    d = s_axi_rvalid ? s_axi_rdata : 32'hDEAD_BEEF;
    resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, 4'hF, r);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    logic [1:0] r;
    axi_read(a, d, r);
  endtask

  task automatic push_exp(input logic [31:0] d);
    wr(ATx, d);
    exp_q.push_back(d);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] d, e;
    rd(ARx, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    check(tag, d, e);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    int n;
    n = 0;
    st = 32'h1;
    while (st[0] && n < 300) begin rd(AStat, st); n++; end
    check(tag, 32'(st[0]), 0);
  endtask

  task automatic wait_bit3(input int base, input string tag);
    int n;
    n = 0;
    while ((sclk_tog - base) < 6 && n < 400) begin @(negedge clk); n++; end
    check(tag, 32'((sclk_tog - base) >= 6), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [1:0] r;
    int base, c0, f2, r2;

    repeat (4) @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 32'hF);
    check("rst_sclk", 32'(spi_sclk), 0);
    check("rst_outs_low", 32'({irq, spi_mosi, s_axi_awready, s_axi_bvalid, s_axi_rvalid,
                               s_axi_arready}), 0);
    resetn = 1'b1;
    rd(AStat, d);  check("rst_status", d, 32'h14);
    rd(ACtrl, d);  check("rst_ctrl", d, 0);

    // Mode 0 loopback, DIV=1.
    wr(ADiv, 1);
    wr(ACtrl, 32'h1);
    base = sclk_tog;
    push_exp(32'hA5);
    wait_idle("a5_busy_clear");
    check("a5_sclk_toggles", sclk_tog - base, 16);
    check("a5_sclk_period", rise_last - rise_prev, 4);
    check("a5_cs_high", 32'(spi_cs_n), 32'hF);
    pop_check("a5_rxdata");

    // wstrb=0 no-op and unmapped write.
    axi_write(ADiv, 32'h55, 4'h0, r);  check("wstrb0_resp", r, 0);
    rd(ADiv, d);                        check("wstrb0_div_kept", d, 1);
    axi_write(12'h040, 32'h1, 4'hF, r); check("unmapped_wr_resp", r, 2'b10);

    // Back-to-back words on cs_n[2].
    wr(ACtrl, 32'h200);
    push_exp(32'h3C);
    push_exp(32'hC3);
    c0 = cs0_fall;  f2 = cs2_fall;  r2 = cs2_rise;
    wr(ACtrl, 32'h201);
    wait_idle("b2b_busy_clear");
    check("b2b_cs2_falls", cs2_fall - f2, 1);
    check("b2b_cs2_rises", cs2_rise - r2, 1);
    check("b2b_cs0_quiet", cs0_fall - c0, 0);
    pop_check("b2b_rx0");
    pop_check("b2b_rx1");

    // Modes 1..3 against the modelled slave.
    slv_on = 1'b1;
    for (int m = 1; m <= 3; m++) begin
      logic [1:0] md;
      md = 2'(m);
      slv_cpol = md[1];
      slv_cpha = md[0];
      wr(ACtrl, {29'b0, md[0], md[1], 1'b0});
      wr(ATx, 32'h00);
      exp_q.push_back(32'h5A);
      wr(ACtrl, {29'b0, md[0], md[1], 1'b1});
      wait_idle("mode_busy_clear");
      check("mode_sclk_idle", 32'(spi_sclk), 32'(md[1]));
      pop_check("mode_rx_5a");
    end
    slv_on = 1'b0;
    wr(ACtrl, 32'h0);

    // TX overfill with EN=0, then flush.
    for (int i = 0; i < int'(DEPTH) + 1; i++) axi_write(ATx, 32'(i + 1), 4'hF, r);
    check("txfull_last_resp", r, 2'b10);
    rd(AStat, d);
    check("txfull_flag", 32'(d[1]), 1);
    check("txfull_level", 32'(d[12:8]), DEPTH);
    wr(ACtrl, 32'h1_0000);
    rd(AStat, d);
    check("txflush_status", d, 32'h14);

    // RX overflow, sticky flag, irq, unmapped read.
    for (int i = 0; i < int'(DEPTH); i++) push_exp(32'(8'h11 * (i + 1)));
    wr(ACtrl, 32'h1);
    wait_idle("ovf_fill_idle");
    wr(ATx, 32'h77);
    wait_idle("ovf_extra_idle");
    rd(AStat, d);
    check("ovf_set", 32'(d[5]), 1);
    check("ovf_rx_full", 32'(d[3]), 1);
    check("ovf_rx_level", 32'(d[20:16]), DEPTH);
    wr(ACtrl, 32'h9);
    check("irq_rx_pending", 32'(irq), 1);
    wr(AStat, 32'h20);
    rd(AStat, d);
    check("ovf_cleared", 32'(d[5]), 0);
    axi_read(12'h014, d, r);
    check("unmapped_rd_resp", r, 2'b10);
    check("unmapped_rd_data", d, 0);
    for (int i = 0; i < int'(DEPTH); i++) pop_check("ovf_drain");
    rd(ARx, d);
    check("rx_empty_reads_0", d, 0);
    check("irq_tx_idle", 32'(irq), 1);
    wr(ACtrl, 32'h1);
    check("irq_disabled", 32'(irq), 0);

    // Abort by clearing EN mid-word.
    wr(ADiv, 3);
    base = sclk_tog;
    wr(ATx, 32'h96);
    wait_bit3(base, "abort_reached");
    wr(ACtrl, 32'h0);
    check("abort_cs_high", 32'(spi_cs_n), 32'hF);
    check("abort_sclk_idle", 32'(spi_sclk), 0);
    base = sclk_tog;
    repeat (30) @(negedge clk);
    check("abort_no_toggles", sclk_tog - base, 0);
    rd(AStat, d);
    check("abort_status", d, 32'h14);

    // Abort by reset mid-word.
    wr(ACtrl, 32'h1);
    base = sclk_tog;
    wr(ATx, 32'h69);
    wait_bit3(base, "reset_reached");
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("reset_cs_high", 32'(spi_cs_n), 32'hF);
    check("reset_sclk_low", 32'(spi_sclk), 0);
    base = sclk_tog;
    repeat (10) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_no_toggles", sclk_tog - base, 0);
    rd(AStat, d);  check("reset_status", d, 32'h14);
    rd(ACtrl, d);  check("reset_ctrl", d, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
